// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Round-robin winner selection: rotate the request vector so the slot after
// ptr_i sits at bit 0, find the first set bit, then map back to a real index.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    idx_o,
    output logic               found_o
);

    localparam logic [ID_W-1:0] ONE = ID_W'(1);

    logic [NUM_REQ-1:0] rot;
    logic [ID_W-1:0]    src;
    logic [ID_W-1:0]    off;

    // Rotate, find-first, un-rotate; index arithmetic wraps modulo NUM_REQ.
    always_comb begin
        rot     = '0;
        src     = '0;
        off     = '0;
        found_o = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            src    = ptr_i + ID_W'(i) + ONE;
            rot[i] = req_i[src];
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found_o && rot[i]) begin
                found_o = 1'b1;
                off     = ID_W'(i);
            end
        end
        idx_o = ptr_i + off + ONE;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered one-hot grant.
// Optional forced revoke after MAX_HOLD busy cycles: define RR_ARBITER8_TIMEOUT_EN.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    if (MAX_HOLD < 1) begin : g_max_hold_check
        $error("rr_arbiter8: MAX_HOLD must be at least 1");
    end

    state_t             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic               gnt_valid_q;
    logic               timeout_q;
    logic [ID_W-1:0]    ptr_q;

    logic [ID_W-1:0]    win_idx;
    logic               win_found;
    logic               release_now;
    logic               revoke;

    rr_pick8 u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .idx_o   (win_idx),
        .found_o (win_found)
    );

    assign release_now = done || !req[gnt_id_q];

`ifdef RR_ARBITER8_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_q;
    logic              expire;

    assign expire = (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign revoke = release_now || expire;
`else
    assign revoke = release_now;
`endif

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '1;
`ifdef RR_ARBITER8_TIMEOUT_EN
            hold_q      <= '0;
`endif
        end else begin
            timeout_q <= 1'b0;
            // A new grant (from IDLE or back-to-back from BUSY) shares one path;
            // ptr_q already points at the releasing index, so it naturally ends
            // up lowest priority.
            if (state_q == IDLE || revoke) begin
`ifdef RR_ARBITER8_TIMEOUT_EN
                if (state_q == BUSY) begin
                    timeout_q <= expire && !release_now;
                end
                hold_q <= '0;
`endif
                if (win_found) begin
                    state_q         <= BUSY;
                    gnt_q           <= '0;
                    gnt_q[win_idx]  <= 1'b1;
                    gnt_id_q        <= win_idx;
                    gnt_valid_q     <= 1'b1;
                    ptr_q           <= win_idx;
                end else begin
                    state_q     <= IDLE;
                    gnt_q       <= '0;
                    gnt_id_q    <= '0;
                    gnt_valid_q <= 1'b0;
                end
            end else begin
`ifdef RR_ARBITER8_TIMEOUT_EN
                hold_q <= hold_q + HOLD_W'(1);
`endif
            end
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and randomised checks of rr_arbiter8 against a scoreboard.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 4;
`ifdef RR_ARBITER8_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       done = 1'b0;
    logic [7:0] req  = '0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        bit         v;
        logic [2:0] id;
        bit         to;
    } exp_t;

    exp_t sbq[$];

    // reference model state for the random phase
    bit         m_busy;
    logic [2:0] m_cur;
    logic [2:0] m_ptr;
    int         m_hold;

    // invariant checker sampling
    logic [7:0] inv_req;
    logic [7:0] inv_gprev;
    logic       inv_rst;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] rq, input logic d, input string tag,
                        input bit ev, input logic [2:0] eid, input bit eto);
        exp_t e;
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = d;
        e.tag = tag;
        e.v   = ev;
        e.id  = eid;
        e.to  = eto;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check({e.tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e.v));
        check({e.tag, ".gnt"}, 32'(gnt), e.v ? (32'd1 << e.id) : 32'd0);
        if (e.v) check({e.tag, ".gnt_id"}, 32'(gnt_id), 32'(e.id));
        check({e.tag, ".timeout"}, 32'(timeout), 32'(e.to));
    endtask

    task automatic model_step(input logic r, input logic [7:0] rq, input logic d,
                              output bit ev, output logic [2:0] eid, output bit eto);
        bit rel;
        bit tmo;
        bit got;
        logic [2:0] w;
        eto = 1'b0;
        if (r) begin
            m_busy = 1'b0;
            m_cur  = '0;
            m_ptr  = 3'd7;
            m_hold = 0;
        end else begin
            rel = m_busy && (d || !rq[m_cur]);
            tmo = m_busy && TMO_EN && !rel && (m_hold == MAX_HOLD - 1);
            if (!m_busy || rel || tmo) begin
                got = 1'b0;
                w   = '0;
                for (int k = 1; k <= 8; k++) begin
                    if (!got && rq[(int'(m_ptr) + k) % 8]) begin
                        got = 1'b1;
                        w   = 3'((int'(m_ptr) + k) % 8);
                    end
                end
                if (got) begin
                    m_busy = 1'b1;
                    m_cur  = w;
                    m_ptr  = w;
                end else begin
                    m_busy = 1'b0;
                    m_cur  = '0;
                end
                m_hold = 0;
                eto    = tmo;
            end else begin
                m_hold++;
            end
        end
        ev  = m_busy;
        eid = m_cur;
    endtask

    // Structural invariants on every cycle.
    always begin
        @(posedge clk);
        inv_req   = req;
        inv_gprev = gnt;
        inv_rst   = rst;
        #1;
        check("inv.onehot0", 32'($onehot0(gnt)), 32'd1);
        check("inv.valid_eq_or", 32'(gnt_valid), 32'(|gnt));
        if (!inv_rst && gnt != '0 && gnt !== inv_gprev)
            check("inv.gnt_requested", 32'(|(gnt & inv_req)), 32'd1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ev;
        logic [2:0] eid;
        bit         eto;
        logic       r;
        logic [7:0] rq;
        logic       d;

        step(1, 8'h00, 0, "rst0", 0, 0, 0);
        step(1, 8'h00, 0, "rst1", 0, 0, 0);
        step(0, 8'h00, 1, "idle_done_ignored", 0, 0, 0);
        step(0, 8'h01, 0, "first_grant", 1, 0, 0);
        step(0, 8'h00, 1, "release_to_idle", 0, 0, 0);

        step(1, 8'h00, 0, "rst2", 0, 0, 0);
        step(0, 8'hFF, 0, "all_req_first", 1, 0, 0);
        for (int k = 1; k <= 8; k++)
            step(0, 8'hFF, 1, $sformatf("rotate%0d", k), 1, 3'(k % 8), 0);
        step(0, 8'hFF, 0, "hold_a", 1, 0, 0);
        step(0, 8'h03, 0, "hold_other_bits", 1, 0, 0);
        step(0, 8'h81, 0, "hold_c", 1, 0, 0);

        step(0, 8'h10, 1, "to_id4", 1, 4, 0);
        step(0, 8'h11, 0, "hold_id4", 1, 4, 0);
        step(0, 8'h11, 1, "id4_done_to_0", 1, 0, 0);
        step(0, 8'h01, 1, "sole_regrant0", 1, 0, 0);
        step(0, 8'h11, 1, "releaser_lowest", 1, 4, 0);
        step(0, 8'h01, 0, "req_drop_release", 1, 0, 0);

        step(0, 8'h40, 1, "to_id6", 1, 6, 0);
        step(0, 8'hC0, 0, "hold_id6", 1, 6, 0);
        step(1, 8'hC0, 1, "rst_mid_grant", 0, 0, 0);
        step(0, 8'hC0, 0, "post_rst_id6", 1, 6, 0);
        step(0, 8'hC0, 1, "next_id7", 1, 7, 0);
        step(0, 8'h81, 1, "wrap_to_0", 1, 0, 0);
        step(0, 8'h00, 1, "back_idle", 0, 0, 0);

`ifdef RR_ARBITER8_TIMEOUT_EN
        step(1, 8'h00, 0, "t_rst", 0, 0, 0);
        step(0, 8'h03, 0, "t_grant0", 1, 0, 0);
        for (int k = 0; k < 3; k++)
            step(0, 8'h03, 0, $sformatf("t_hold%0d", k), 1, 0, 0);
        step(0, 8'h03, 0, "t_fire", 1, 1, 1);
        step(0, 8'h03, 0, "t_pulse_end", 1, 1, 0);
        step(0, 8'h03, 0, "t_h2", 1, 1, 0);
        step(0, 8'h03, 0, "t_h3", 1, 1, 0);
        step(0, 8'h03, 1, "t_done_same_edge", 1, 0, 0);
`else
        step(1, 8'h00, 0, "n_rst", 0, 0, 0);
        step(0, 8'h03, 0, "n_grant0", 1, 0, 0);
        for (int k = 0; k < 20; k++)
            step(0, 8'h03, 0, $sformatf("n_hold%0d", k), 1, 0, 0);
`endif

        for (int i = 0; i < 300; i++) begin
            r  = (i == 0) || ($urandom_range(0, 49) == 0);
            rq = 8'($urandom & $urandom);
            d  = ($urandom_range(0, 3) == 0);
            model_step(r, rq, d, ev, eid, eto);
            step(r, rq, d, $sformatf("rand%0d", i), ev, eid, eto);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
